// File: rtl/fact_arbiter.sv
// Two-requester arbiter in front of a factorial datapath: grants round-robin,
// validates the operand, launches the job and guards the Busy handshake with timeouts.
module fact_arbiter #(
    parameter int WD_CYCLES  = 63,
    parameter int ACK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] opnd_a,
    input  logic       req_b,
    input  logic [7:0] opnd_b,
    input  logic       Busy,
    input  logic [7:0] Result,
    output logic       Start,
    output logic [7:0] A,
    output logic       grant_a,
    output logic       grant_b,
    output logic       done_a,
    output logic       done_b,
    output logic       err_a,
    output logic       err_b,
    output logic [7:0] res,
    output logic [2:0] state_dbg
);

    // Requests are levels held until done_x/err_x; the owner sees exactly one of those pulses.
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] LAUNCH   = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] RUN      = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] FAIL     = 3'd6;

    localparam logic [5:0] ACK_LAST = 6'(ACK_CYCLES - 1);
    localparam logic [5:0] WD_LAST  = 6'(WD_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [5:0] cnt;
    logic       last_b;
    logic       pick_b;

    // B wins only when A is absent or A was the one served last.
    assign pick_b = req_b && (!req_a || !last_b);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_a || req_b) next_state = CHECK;
            CHECK:    next_state = (A >= 8'd1 && A <= 8'd5) ? LAUNCH : FAIL;
            LAUNCH:   next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (Busy)                 next_state = RUN;
                else if (cnt >= ACK_LAST) next_state = FAIL;
            end
            RUN: begin
                if (!Busy)               next_state = DONE;
                else if (cnt >= WD_LAST) next_state = FAIL;
            end
            DONE:     next_state = IDLE;
            FAIL:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            last_b  <= 1'b1;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            A       <= 8'd0;
            res     <= 8'd0;
        end else begin
            state <= next_state;
            // Saturating cycle counter restarted on every state change.
            if (next_state != state)
                cnt <= 6'd0;
            else if (cnt != 6'h3f)
                cnt <= cnt + 6'd1;
            if (state == IDLE && next_state == CHECK) begin
                grant_a <= !pick_b;
                grant_b <= pick_b;
                A       <= pick_b ? opnd_b : opnd_a;
            end
            if (state == RUN && !Busy)
                res <= Result;
            if (state == DONE || state == FAIL) begin
                grant_a <= 1'b0;
                grant_b <= 1'b0;
                last_b  <= grant_b;
            end
        end
    end

    assign Start     = (state == LAUNCH);
    assign done_a    = (state == DONE) && grant_a;
    assign done_b    = (state == DONE) && grant_b;
    assign err_a     = (state == FAIL) && grant_a;
    assign err_b     = (state == FAIL) && grant_b;
    assign state_dbg = state;

endmodule

// File: tb/tb_fact_arbiter.sv
// Bench for fact_arbiter: a timed datapath model answers Start, and a job-level
// reference model predicts winner, outcome, latency and result of every round.
module tb_fact_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [7:0] opnd_a, opnd_b;
    logic       Busy;
    logic [7:0] Result;
    logic       Start;
    logic [7:0] A;
    logic       grant_a, grant_b, done_a, done_b, err_a, err_b;
    logic [7:0] res;
    logic [2:0] state_dbg;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    int         dp_d, dp_b;
    bit         dp_active;
    logic [7:0] dp_n;
    bit         model_last_b;

    always #5 clk = ~clk;

    fact_arbiter #(.WD_CYCLES(63), .ACK_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .opnd_a(opnd_a), .req_b(req_b), .opnd_b(opnd_b),
        .Busy(Busy), .Result(Result),
        .Start(Start), .A(A),
        .grant_a(grant_a), .grant_b(grant_b),
        .done_a(done_a), .done_b(done_b), .err_a(err_a), .err_b(err_b),
        .res(res), .state_dbg(state_dbg)
    );

    function automatic logic [7:0] fact8(input logic [7:0] n);
        int f = 1;
        for (int i = 2; i <= int'(n); i++) f = f * i;
        return f[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: Busy rises dp_d cycles after the Start cycle and stays high dp_b cycles.
    initial begin : datapath
        Busy = 1'b0; Result = 8'd0; dp_active = 1'b0;
        forever begin
            @(negedge clk);
            if (Start === 1'b1) begin
                dp_active = 1'b1;
                dp_n = A;
                @(posedge clk);
                if (dp_d < 100) begin
                    repeat (dp_d) @(posedge clk);
                    #1; Busy = 1'b1; Result = fact8(dp_n);
                    repeat (dp_b) @(posedge clk);
                    #1; Busy = 1'b0;
                end
                dp_active = 1'b0;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        model_last_b = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("reset_outputs", {Start, grant_a, grant_b, done_a, done_b, err_a, err_b, A, res}, 0);
    endtask

    task automatic wait_dp_idle();
        int w = 0;
        while (dp_active && w < 200) begin @(negedge clk); w++; end
        if (dp_active) check("dp_idle_timeout", dp_active, 0);
    endtask

    // One job. fresh=0 means the requests are already pending in the current IDLE cycle.
    task automatic do_round(input bit ra, input bit rb, input logic [7:0] na, input logic [7:0] nb,
                            input int d, input int b, input bit fresh, input bit hold);
        bit         win_b, exp_err, seen, bad, got_done;
        logic [7:0] n;
        int         exp_t, t, starts;
        win_b = rb && (!ra || !model_last_b);
        n = win_b ? nb : na;
        exp_err = 1'b1;
        if (!(n >= 1 && n <= 5))  exp_t = 2;
        else if (d >= 4)          exp_t = 7;
        else if (b >= 64)         exp_t = d + 67;
        else begin exp_err = 1'b0; exp_t = d + b + 4; exp_q.push_back(fact8(n)); end
        dp_d = d; dp_b = b;
        if (fresh) begin
            @(posedge clk); #1;
            req_a = ra; req_b = rb; opnd_a = na; opnd_b = nb;
            @(negedge clk);
        end
        @(negedge clk);
        check("grant_a", grant_a, !win_b);
        check("grant_b", grant_b, win_b);
        if (!hold) begin opnd_a = 8'($urandom); opnd_b = 8'($urandom); end
        t = 1; starts = 0; bad = 1'b0; seen = 1'b0;
        while (!seen && t < 300) begin
            if (Start) begin starts++; if (A !== n) bad = 1'b1; end
            if ((done_a || done_b) && (err_a || err_b)) bad = 1'b1;
            if (grant_a !== !win_b || grant_b !== win_b) bad = 1'b1;
            if (done_a || done_b || err_a || err_b) seen = 1'b1;
            else begin @(negedge clk); t++; end
        end
        check("completion_timeout", seen, 1);
        got_done = done_a || done_b;
        if (seen) begin
            check("latency", t, exp_t);
            check("done_a", done_a, !exp_err && !win_b);
            check("done_b", done_b, !exp_err && win_b);
            check("err_a", err_a, exp_err && !win_b);
            check("err_b", err_b, exp_err && win_b);
            check("start_count", starts, (n >= 1 && n <= 5) ? 1 : 0);
            check("protocol", bad, 0);
            if (got_done) begin
                if (exp_q.size() == 0) check("unexpected_done", got_done, 0);
                else check("res", res, exp_q.pop_front());
            end
        end
        exp_q.delete();
        model_last_b = win_b;
        @(posedge clk); #1;
        if (!hold) begin req_a = 1'b0; req_b = 1'b0; end
        else begin opnd_a = na; opnd_b = nb; end
        @(negedge clk);
        check("grant_clear", {grant_a, grant_b}, 0);
        if (got_done) check("res_hold", res, fact8(n));
        wait_dp_idle();
    endtask

    task automatic reset_mid_run();
        bit seen_out = 1'b0;
        int w = 0;
        dp_d = 0; dp_b = 30;
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b0; opnd_a = 8'd4;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("run_before_reset", grant_a, 1);
        @(posedge clk); #1;
        reset = 1'b1; req_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", {Start, grant_a, grant_b, done_a, done_b, err_a, err_b, A, res}, 0);
        while (w < 40) begin
            if (done_a || done_b || err_a || err_b || grant_a || grant_b || Start) seen_out = 1'b1;
            @(negedge clk); w++;
        end
        check("no_pulse_after_reset", seen_out, 0);
        model_last_b = 1'b1;
        exp_q.delete();
        wait_dp_idle();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit         ra, rb;
        int         d, b;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; opnd_a = 8'd0; opnd_b = 8'd0;
        dp_d = 0; dp_b = 1; model_last_b = 1'b1;
        apply_reset();

        do_round(1, 0, 8'd5, 8'd0, 0, 20, 1, 0);
        apply_reset();
        do_round(1, 1, 8'd3, 8'd4, 0, 6, 1, 1);
        do_round(1, 1, 8'd3, 8'd4, 0, 6, 0, 1);
        do_round(1, 1, 8'd3, 8'd4, 0, 6, 0, 0);

        do_round(0, 1, 8'd0, 8'd0, 0, 5, 1, 0);
        do_round(0, 1, 8'd0, 8'd6, 0, 5, 1, 0);
        do_round(1, 0, 8'd1, 8'd0, 0, 3, 1, 0);

        do_round(1, 0, 8'd2, 8'd0, 200, 0, 1, 0);
        do_round(1, 0, 8'd2, 8'd0, 3, 4, 1, 0);
        do_round(1, 0, 8'd2, 8'd0, 4, 4, 1, 0);

        do_round(0, 1, 8'd0, 8'd3, 0, 80, 1, 0);
        do_round(0, 1, 8'd0, 8'd3, 0, 10, 1, 0);
        do_round(1, 0, 8'd4, 8'd0, 1, 63, 1, 0);
        do_round(1, 0, 8'd4, 8'd0, 1, 64, 1, 0);

        do_round(1, 0, 8'd2, 8'd0, 0, 4, 1, 0);
        reset_mid_run();
        do_round(1, 1, 8'd2, 8'd3, 0, 5, 1, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            d = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 5));
            b = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 25)) : int'($urandom_range(60, 66));
            do_round(ra, rb, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), d, b, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
